// File: rtl/rv_pkg.sv
// Shared pipeline constants and the write-port scheduler state encoding.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_X0 = '0;

  typedef enum logic {
    IDLE   = 1'b0,
    STARVE = 1'b1
  } sched_state_e;
endpackage

// File: rtl/regs_scoreboard.sv
// Busy-bit scoreboard for long-unit destinations, with RAW/WAW hazard detection at issue.
module regs_scoreboard
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_long,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_rd,
  output logic            iss_stall,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic            hazard;
  logic            set_en;

  assign hazard    = iss_valid & (busy_reg[iss_rs1] | busy_reg[iss_rs2] | busy_reg[iss_rd]);
  assign iss_stall = hazard;
  assign set_en    = iss_valid & ~hazard & iss_long & (iss_rd != REG_X0);
  assign busy      = busy_reg;

  // Set is checked after clear so a same-edge set on the same index wins.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_next[gi] = 1'b0;
      end else begin : g_rn
        logic set_hit;
        logic clr_hit;
        assign set_hit       = set_en & (iss_rd == AW'(gi));
        assign clr_hit       = clr_en & (clr_rd == AW'(gi));
        assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

endmodule

// File: rtl/regs_wb_sched.sv
// Write-port arbiter between pipeline writeback and the long unit, with
// scoreboard hookup and a starvation monitor that asks upstream for bubbles.
module regs_wb_sched
  import rv_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_long,
  output logic            iss_stall,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lu_valid,
  input  logic [AW-1:0]   lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] wb,
  output logic            RegWen,
  output logic [NREG-1:0] busy,
  output logic            drain_req
);

  logic [AW-1:0]   rd_reg;
  logic [XLEN-1:0] wb_reg;
  logic            regwen_reg;
  logic            lu_commit_reg;
  logic [3:0]      count_reg;
  logic [3:0]      count_next;
  sched_state_e    state_reg;
  sched_state_e    state_next;
  logic            drain_reg;
  logic            lu_acc;
  logic            blocked;

  assign lu_ready  = ~wb_valid;
  assign lu_acc    = lu_valid & ~wb_valid;
  assign blocked   = lu_valid & wb_valid;
  assign rd        = rd_reg;
  assign wb        = wb_reg;
  assign RegWen    = regwen_reg;
  assign drain_req = drain_reg;

  // lu_commit_reg marks that the write on the port this cycle came from the
  // long unit, so the scoreboard clears its busy bit on the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_reg        <= '0;
      wb_reg        <= '0;
      regwen_reg    <= 1'b0;
      lu_commit_reg <= 1'b0;
    end else if (wb_valid) begin
      rd_reg        <= wb_rd;
      wb_reg        <= wb_data;
      regwen_reg    <= (wb_rd != REG_X0);
      lu_commit_reg <= 1'b0;
    end else if (lu_acc) begin
      rd_reg        <= lu_rd;
      wb_reg        <= lu_data;
      regwen_reg    <= (lu_rd != REG_X0);
      lu_commit_reg <= (lu_rd != REG_X0);
    end else begin
      regwen_reg    <= 1'b0;
      lu_commit_reg <= 1'b0;
    end
  end

  regs_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_long  (iss_long),
    .clr_en    (lu_commit_reg),
    .clr_rd    (rd_reg),
    .iss_stall (iss_stall),
    .busy      (busy)
  );

  // The transition looks at the updated count so drain_req is high in the
  // cycle right after the STARVE_LIM-th blocked cycle.
  always_comb begin
    count_next = 4'd0;
    state_next = state_reg;
    if (blocked) begin
      count_next = (count_reg == 4'hF) ? count_reg : count_reg + 4'd1;
    end
    case (state_reg)
      IDLE:    if (count_next == 4'(STARVE_LIM)) state_next = STARVE;
      STARVE:  if (lu_acc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 4'd0;
      state_reg <= IDLE;
      drain_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      state_reg <= state_next;
      drain_reg <= (state_next == STARVE);
    end
  end

endmodule

// File: tb/tb_regs_wb_sched.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level reference model of the write port, scoreboard and starvation rule.
module tb_regs_wb_sched;
  import rv_pkg::*;

  localparam int LIM = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            iss_valid, iss_long, iss_stall;
  logic [AW-1:0]   iss_rs1, iss_rs2, iss_rd;
  logic            wb_valid, lu_valid, lu_ready;
  logic [AW-1:0]   wb_rd, lu_rd, rd;
  logic [XLEN-1:0] wb_data, lu_data, wb;
  logic            RegWen, drain_req;
  logic [NREG-1:0] busy;

  int checks = 0;
  int failures = 0;

  // Reference model state: what the write port shows, which registers await
  // long results, how long the LU has been blocked, and the drain flag.
  logic [NREG-1:0] m_busy;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_wb;
  bit              m_wen, m_is_lu, m_drain;
  int              m_blocked;
  logic [AW-1:0]   lu_q[$];
  logic [XLEN-1:0] regs_mem [NREG];

  regs_wb_sched #(.STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_long(iss_long), .iss_stall(iss_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rd(rd), .wb(wb), .RegWen(RegWen), .busy(busy), .drain_req(drain_req)
  );

  always #5 clk = ~clk;

  // Stand-in for the register file: commits whatever the port presents.
  always @(posedge clk) if (RegWen) regs_mem[rd] <= wb;

  task automatic idle_inputs();
    iss_valid = 0; iss_long = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  task automatic model_reset();
    m_busy = '0; m_rd = '0; m_wb = '0; m_wen = 0; m_is_lu = 0;
    m_drain = 0; m_blocked = 0;
    lu_q.delete();
  endtask

  // Advances one clock: evaluates the model on the inputs held before the edge.
  task automatic cycle();
    logic [NREG-1:0] nb;
    bit stall_m;
    stall_m = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
    nb = m_busy;
    if (m_wen && m_is_lu) nb[m_rd] = 1'b0;
    if (iss_valid && !stall_m && iss_long && iss_rd != 0) begin
      nb[iss_rd] = 1'b1;
      lu_q.push_back(iss_rd);
    end
    if (lu_valid && wb_valid) begin
      m_blocked++;
      if (m_blocked == LIM) m_drain = 1;
    end else begin
      m_blocked = 0;
      if (lu_valid) m_drain = 0;
    end
    if (lu_valid && !wb_valid && lu_q.size() > 0 && lu_q[0] == lu_rd) void'(lu_q.pop_front());
    @(posedge clk);
    m_busy = nb;
    if (wb_valid) begin
      m_rd = wb_rd; m_wb = wb_data; m_wen = (wb_rd != 0); m_is_lu = 0;
    end else if (lu_valid) begin
      m_rd = lu_rd; m_wb = lu_data; m_wen = (lu_rd != 0); m_is_lu = 1;
    end else begin
      m_wen = 0; m_is_lu = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (RegWen !== 1'b0) begin failures++; $display("FAIL reset_regwen got=%0b want=0", RegWen); end
    checks++; if (rd !== '0 || wb !== '0) begin failures++; $display("FAIL reset_rd_wb got rd=%0d wb=%h want 0/0", rd, wb); end
    checks++; if (busy !== '0) begin failures++; $display("FAIL reset_busy got=%h want=0", busy); end
    checks++; if (drain_req !== 1'b0) begin failures++; $display("FAIL reset_drain got=%0b want=0", drain_req); end
    checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL reset_lu_ready got=%0b want=1", lu_ready); end
    $display("test_reset done");
  endtask

  task automatic test_wb_only();
    @(negedge clk); idle_inputs();
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    cycle();
    checks++; if (RegWen !== 1'b1 || rd !== 5'd5 || wb !== 32'hDEADBEEF) begin failures++;
      $display("FAIL wb_only_port got wen=%0b rd=%0d wb=%h want 1/5/deadbeef", RegWen, rd, wb); end
    @(negedge clk); idle_inputs();
    cycle();
    checks++; if (regs_mem[5] !== 32'hDEADBEEF) begin failures++; $display("FAIL wb_only_regs got=%h want=deadbeef", regs_mem[5]); end
    checks++; if (RegWen !== 1'b0 || rd !== 5'd5 || wb !== 32'hDEADBEEF) begin failures++;
      $display("FAIL wb_only_hold got wen=%0b rd=%0d wb=%h want 0/5/deadbeef", RegWen, rd, wb); end
    $display("test_wb_only wb x5=deadbeef");
  endtask

  task automatic test_contention();
    @(negedge clk); idle_inputs();
    wb_valid = 1; wb_rd = 5; wb_data = 32'h0000_AAAA;
    lu_valid = 1; lu_rd = 7; lu_data = 32'h0000_7777;
    #1;
    checks++; if (lu_ready !== 1'b0) begin failures++; $display("FAIL contend_ready got=%0b want=0", lu_ready); end
    cycle();
    checks++; if (RegWen !== 1'b1 || rd !== 5'd5 || wb !== 32'h0000_AAAA) begin failures++;
      $display("FAIL contend_wb_wins got wen=%0b rd=%0d wb=%h want 1/5/0000aaaa", RegWen, rd, wb); end
    @(negedge clk); wb_valid = 0;
    #1;
    checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL contend_ready2 got=%0b want=1", lu_ready); end
    cycle();
    checks++; if (RegWen !== 1'b1 || rd !== 5'd7 || wb !== 32'h0000_7777) begin failures++;
      $display("FAIL contend_lu got wen=%0b rd=%0d wb=%h want 1/7/00007777", RegWen, rd, wb); end
    @(negedge clk); idle_inputs();
    cycle();
    checks++; if (regs_mem[5] !== 32'h0000_AAAA || regs_mem[7] !== 32'h0000_7777) begin failures++;
      $display("FAIL contend_regs got x5=%h x7=%h want 0000aaaa/00007777", regs_mem[5], regs_mem[7]); end
    $display("test_contention wb x5 then lu x7");
  endtask

  task automatic test_raw_stall();
    @(negedge clk); idle_inputs();
    iss_valid = 1; iss_long = 1; iss_rd = 3;
    #1;
    checks++; if (iss_stall !== 1'b0) begin failures++; $display("FAIL raw_issue_free got=%0b want=0", iss_stall); end
    cycle();
    checks++; if (busy !== 32'h0000_0008) begin failures++; $display("FAIL raw_busy_set got=%h want=00000008", busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_inputs();
      iss_valid = 1; iss_rs1 = 3; iss_rd = 1;
      #1;
      checks++; if (iss_stall !== 1'b1) begin failures++; $display("FAIL raw_stall_wait%0d got=%0b want=1", i, iss_stall); end
      cycle();
    end
    @(negedge clk); lu_valid = 1; lu_rd = 3; lu_data = 32'h00C0FFEE;
    #1;
    checks++; if (iss_stall !== 1'b1) begin failures++; $display("FAIL raw_stall_accept got=%0b want=1", iss_stall); end
    cycle();
    @(negedge clk); lu_valid = 0;
    #1;
    checks++; if (iss_stall !== 1'b1) begin failures++; $display("FAIL raw_stall_commit got=%0b want=1", iss_stall); end
    cycle();
    checks++; if (busy !== '0) begin failures++; $display("FAIL raw_busy_clear got=%h want=0", busy); end
    @(negedge clk); #1;
    checks++; if (iss_stall !== 1'b0) begin failures++; $display("FAIL raw_unstall got=%0b want=0", iss_stall); end
    checks++; if (regs_mem[3] !== 32'h00C0FFEE) begin failures++; $display("FAIL raw_regs got=%h want=00c0ffee", regs_mem[3]); end
    idle_inputs();
    cycle();
    $display("test_raw_stall x3 released after commit");
  endtask

  task automatic test_x0_waw();
    @(negedge clk); idle_inputs();
    iss_valid = 1; iss_long = 1; iss_rd = 0;
    cycle();
    checks++; if (busy !== '0) begin failures++; $display("FAIL x0_busy got=%h want=0", busy); end
    @(negedge clk); iss_rd = 4;
    cycle();
    @(negedge clk); #1;
    checks++; if (iss_stall !== 1'b1) begin failures++; $display("FAIL waw_stall got=%0b want=1", iss_stall); end
    idle_inputs();
    lu_valid = 1; lu_rd = 0; lu_data = 32'h1111_2222;
    #1;
    checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL x0_lu_ready got=%0b want=1", lu_ready); end
    cycle();
    checks++; if (RegWen !== 1'b0) begin failures++; $display("FAIL x0_regwen got=%0b want=0", RegWen); end
    @(negedge clk); lu_rd = 4; lu_data = 32'h4444_4444;
    cycle();
    @(negedge clk); idle_inputs();
    cycle();
    checks++; if (busy !== '0 || regs_mem[4] !== 32'h4444_4444) begin failures++;
      $display("FAIL waw_done got busy=%h x4=%h want 0/44444444", busy, regs_mem[4]); end
    $display("test_x0_waw done");
  endtask

  task automatic test_starvation();
    @(negedge clk); idle_inputs();
    lu_valid = 1; lu_rd = 9; lu_data = 32'h9999_0000;
    wb_valid = 1; wb_rd = 10;
    for (int k = 1; k <= 6; k++) begin
      wb_data = 32'(k);
      cycle();
      checks++; if (drain_req !== (k >= LIM)) begin failures++;
        $display("FAIL starve_blocked%0d got=%0b want=%0b", k, drain_req, (k >= LIM)); end
      @(negedge clk);
    end
    wb_valid = 0;
    #1;
    checks++; if (drain_req !== 1'b1) begin failures++; $display("FAIL starve_accept_cycle got=%0b want=1", drain_req); end
    cycle();
    checks++; if (drain_req !== 1'b0 || rd !== 5'd9 || RegWen !== 1'b1) begin failures++;
      $display("FAIL starve_release got drain=%0b rd=%0d wen=%0b want 0/9/1", drain_req, rd, RegWen); end
    @(negedge clk); idle_inputs();
    cycle();
    $display("test_starvation drain cleared after accept");
  endtask

  task automatic test_random();
    bit hold_lu = 0;
    int n = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      iss_valid = ($urandom_range(0, 1) == 1) && c < 560;
      iss_rs1 = AW'($urandom); iss_rs2 = AW'($urandom); iss_rd = AW'($urandom);
      iss_long = ($urandom_range(0, 2) == 0);
      wb_valid = ($urandom_range(0, 1) == 1);
      wb_rd = AW'($urandom);
      if (m_busy[wb_rd]) wb_rd = 0;
      wb_data = $urandom;
      if (!hold_lu) begin
        lu_valid = (lu_q.size() > 0) && ($urandom_range(0, 2) != 0);
        if (lu_valid) begin lu_rd = lu_q[0]; lu_data = $urandom; end
      end
      #1;
      checks++; if (iss_stall !== (iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]))) begin
        failures++; $display("FAIL rnd_stall c=%0d got=%0b busy=%h", c, iss_stall, m_busy); end
      checks++; if (lu_ready !== !wb_valid) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, lu_ready, !wb_valid); end
      checks++; if (wb_valid && busy[wb_rd]) begin failures++; $display("FAIL rnd_wb_to_busy c=%0d rd=%0d", c, wb_rd); end
      hold_lu = lu_valid && wb_valid;
      cycle();
      n++;
      checks++; if (RegWen !== m_wen || busy !== m_busy || drain_req !== m_drain) begin failures++;
        $display("FAIL rnd_state c=%0d got wen=%0b busy=%h drain=%0b want %0b/%h/%0b", c, RegWen, busy, drain_req, m_wen, m_busy, m_drain); end
      checks++; if (m_wen && (rd !== m_rd || wb !== m_wb)) begin failures++;
        $display("FAIL rnd_port c=%0d got rd=%0d wb=%h want %0d/%h", c, rd, wb, m_rd, m_wb); end
    end
    $display("test_random %0d cycles, %0d long ops outstanding", n, lu_q.size());
  endtask

  task automatic test_async_reset();
    logic [XLEN-1:0] old11;
    do_reset();
    @(negedge clk); iss_valid = 1; iss_long = 1; iss_rd = 3;
    cycle();
    @(negedge clk); iss_rd = 4;
    cycle();
    @(negedge clk); idle_inputs();
    wb_valid = 1; wb_rd = 11; wb_data = 32'h1234_5678;
    lu_valid = 1; lu_rd = 3;
    cycle();
    checks++; if (busy !== 32'h0000_0018 || RegWen !== 1'b1) begin failures++;
      $display("FAIL areset_setup got busy=%h wen=%0b want 00000018/1", busy, RegWen); end
    old11 = regs_mem[11];
    #1 rst_n = 0;
    #1;
    checks++; if (RegWen !== 1'b0 || busy !== '0 || drain_req !== 1'b0) begin failures++;
      $display("FAIL areset_immediate got wen=%0b busy=%h drain=%0b want 0/0/0", RegWen, busy, drain_req); end
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (regs_mem[11] !== old11) begin failures++; $display("FAIL areset_no_write got=%h want=%h", regs_mem[11], old11); end
    @(negedge clk); rst_n = 1; model_reset();
    $display("test_async_reset pending write discarded");
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) regs_mem[i] = '0;
    model_reset();
    test_reset();
    test_wb_only();
    test_contention();
    test_raw_stall();
    test_x0_waw();
    test_starvation();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regs_wb_sched.md
Name: regs_wb_sched

Overview:
- Write-port scheduler and scoreboard for the `regs` register file (single write port, two read ports) in the RISC-V pipeline.
- Shares the one write port between two requesters:
  - the in-order pipeline writeback, which has fixed priority and cannot be back-pressured;
  - a long-latency unit (mul/div/load-miss), which uses a valid/ready handshake.
- Keeps a busy bit per architectural register for outstanding long-unit destinations, and stalls issue on RAW/WAW hazards against them.
- Raises a drain request to upstream when the long unit is starved of write-port slots.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers.
- AW, 5, register index width (log2 NREG).
- STARVE_LIM, 4, consecutive blocked cycles of a valid long-unit request before drain_req asserts; range 1..15.

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst_n, input, 1, reset.
- iss_valid, input, 1, an instruction is in decode/issue this cycle.
- iss_rs1, input, AW, source 1 index.
- iss_rs2, input, AW, source 2 index.
- iss_rd, input, AW, destination index.
- iss_long, input, 1, the instruction completes in the long unit.
- iss_stall, output, 1, hold issue this cycle (combinational).
- wb_valid, input, 1, pipeline writeback this cycle (always accepted).
- wb_rd, input, AW, pipeline writeback destination.
- wb_data, input, XLEN, pipeline writeback data.
- lu_valid, input, 1, long-unit result valid.
- lu_rd, input, AW, long-unit destination.
- lu_data, input, XLEN, long-unit data.
- lu_ready, output, 1, long-unit result accepted this cycle (combinational).
- rd, output, AW, to regs.rd (registered).
- wb, output, XLEN, to regs.wb (registered).
- RegWen, output, 1, to regs.RegWen (registered).
- busy, output, NREG, scoreboard vector, for debug and the bench.
- drain_req, output, 1, request upstream to insert bubbles (registered).

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-low on rst_n. Reset clears rd, wb, RegWen, busy, drain_req and the starvation counter to 0. Reset mid-operation discards the pending write and all busy bits.
- Arbitration:
  - lu_ready = ~wb_valid.
  - Pipeline WB always wins the write port.
  - The long unit is accepted only in cycles with no pipeline WB.
- Write path:
  - The accepted request (WB, or LU when lu_valid & lu_ready) is registered at edge N.
  - It is presented on rd/wb/RegWen during cycle N+1; regs commits it at edge N+1.
  - Latency from accept to commit: 1 cycle.
- x0 handling:
  - A request with destination 0 is consumed: the handshake completes, but RegWen stays 0 for that slot.
  - busy[0] is constant 0.
- No accepted request at edge N: RegWen = 0 in cycle N+1; rd and wb hold their previous values.
- Scoreboard:
  - Hazard = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]). The iss_rd term covers WAW.
  - iss_stall = hazard.
  - Set: busy[iss_rd] sets at the edge when iss_valid & ~iss_stall & iss_long & iss_rd != 0.
  - Clear: busy[lu_rd] clears at the edge where the long write commits (edge N+1 above). Issue therefore unstalls in cycle N+2 and reads committed data.
  - Same edge set and clear on the same index: set wins.
  - A pipeline WB to a busy register is illegal (prevented by the WAW stall). The bench asserts it never occurs.
- Starvation:
  - The 4-bit counter increments each cycle with lu_valid & wb_valid, saturating at 15.
  - It clears on any cycle with ~lu_valid or lu_ready.
  - drain_req is registered: it is 1 in the cycle after the counter reaches STARVE_LIM and stays 1 until the cycle after the LU request is accepted.
- State machine, 2 states:
  - IDLE → STARVE when count == STARVE_LIM.
  - STARVE → IDLE after LU accept.
  - Reset → IDLE.

Decomposition:
- Shared package (rv_pkg): XLEN, NREG, AW, the REG_X0 constant, and the sched state enum (IDLE, STARVE).
- One sub-module: regs_scoreboard. It holds the busy vector, the set/clear/priority logic and the hazard compare.
- The arbiter, write register and starvation FSM stay in the top.

Test Plan:
- Pipeline WB only: wb_valid=1, wb_rd=5, wb_data=32'hDEADBEEF at edge N → cycle N+1 shows rd=5, wb=DEADBEEF, RegWen=1; regs reads x5 = DEADBEEF after edge N+1.
- Contention: wb_valid=1 and lu_valid=1 (lu_rd=7) in the same cycle → lu_ready=0 and only x5 is written. Next cycle wb_valid=0 → lu_ready=1 and x7 is written one cycle later.
- RAW stall:
  - Issue long rd=3 → busy[3]=1.
  - Issue rs1=3 → iss_stall=1 until the LU write to x3 commits.
  - iss_stall=0 in the cycle after the commit.
- x0 and WAW:
  - Long issue with rd=0 → busy stays 0.
  - LU result with lu_rd=0 → lu_ready=1 and RegWen=0.
  - Long issue rd=4 while busy[4]=1 → iss_stall=1.
- Starvation (STARVE_LIM=4): lu_valid held with wb_valid=1 for 6 cycles → drain_req rises after the 4th blocked cycle. Drop wb_valid → LU accepted; drain_req falls the next cycle.
- Async reset mid-operation: assert rst_n=0 between clock edges with busy=0x0000_0018 and a pending write → RegWen, busy and drain_req read 0 immediately; no write reaches regs.
